// File: rtl/tff_bank_counter.sv
// rtl/tff_bank_counter.sv - WIDTH-bit T flip-flop bank / modulo-MOD up/down counter
module tff_bank_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             ck,
  input  logic             rs,
  input  logic [1:0]       mode,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_COUNT  = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  // One extra bit so MOD == 2^WIDTH is representable in the range compares.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] toggled;

  assign toggled = q_q ^ d;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    case (mode)
      MODE_COUNT: begin
        if (up) begin
          if (q_q == MAX_Q) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q + ONE_Q;
          end
        end else begin
          if (q_q == '0) begin
            q_d    = MAX_Q;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q - ONE_Q;
          end
        end
      end
      MODE_TOGGLE: begin
        if ({1'b0, toggled} < MOD_W) begin
          q_d = toggled;
        end else begin
          q_d   = '0;
          err_d = 1'b1;
        end
      end
      MODE_LOAD: begin
        if ({1'b0, d} < MOD_W) begin
          q_d = d;
        end else begin
          q_d   = '0;
          err_d = 1'b1;
        end
      end
      MODE_HOLD: q_d = q_q;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rs) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  // Terminal count looks at the live mode/up so a direction flip is seen the same cycle.
  always_comb begin
    tc = 1'b0;
    if (mode == MODE_COUNT) begin
      tc = up ? (q_q == MAX_Q) : (q_q == '0);
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_tff_bank_counter.sv
// tb/tb_tff_bank_counter.sv - scoreboard bench for tff_bank_counter in three configurations
module tb_tff_bank_counter;

  logic       ck = 1'b0;
  logic       rs = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       up = 1'b0;
  logic [3:0] d = 4'd0;

  logic [3:0] q_a, q_b;
  logic       q_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       err_a, err_b, err_c;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int       sel;
    logic [3:0] q;
    logic     tc;
    logic     wrap;
    logic     err;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   aq, atc, awrap, aerr;

  always #5 ck = ~ck;

  tff_bank_counter #(.WIDTH(4), .MOD(10)) u_a (
    .ck(ck), .rs(rs), .mode(mode), .up(up), .d(d),
    .q(q_a), .tc(tc_a), .wrap(wrap_a), .err(err_a)
  );

  tff_bank_counter #(.WIDTH(4), .MOD(16)) u_b (
    .ck(ck), .rs(rs), .mode(mode), .up(up), .d(d),
    .q(q_b), .tc(tc_b), .wrap(wrap_b), .err(err_b)
  );

  tff_bank_counter #(.WIDTH(1), .MOD(2)) u_c (
    .ck(ck), .rs(rs), .mode(mode), .up(up), .d(d[0]),
    .q(q_c), .tc(tc_c), .wrap(wrap_c), .err(err_c)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge that had stimulus behind it has one queued expectation.
  always @(posedge ck) begin
    #1;
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      case (m_e.sel)
        0:       begin aq = q_a; atc = tc_a; awrap = wrap_a; aerr = err_a; end
        1:       begin aq = q_b; atc = tc_b; awrap = wrap_b; aerr = err_b; end
        default: begin aq = q_c; atc = tc_c; awrap = wrap_c; aerr = err_c; end
      endcase
      chk($sformatf("dut%0d_q", m_e.sel), aq, m_e.q);
      chk($sformatf("dut%0d_tc", m_e.sel), atc, m_e.tc);
      chk($sformatf("dut%0d_wrap", m_e.sel), awrap, m_e.wrap);
      chk($sformatf("dut%0d_err", m_e.sel), aerr, m_e.err);
    end
  end

  task automatic step(input int sel, input logic r, input logic [1:0] m, input logic u,
                      input logic [3:0] dv, input logic [3:0] eq, input logic etc,
                      input logic ew, input logic ee, input bit mid_rs = 1'b0);
    exp_t e;
    rs = r; mode = m; up = u; d = dv;
    e.sel = sel; e.q = eq; e.tc = etc; e.wrap = ew; e.err = ee;
    sb.push_back(e);
    if (mid_rs) begin
      #1 rs = 1'b0;
      #1 chk("rs_no_async_effect", q_a, 7);
    end
    @(posedge ck);
    #2;
  endtask

  initial begin
    @(posedge ck);
    #2;

    // DUT A: WIDTH=4, MOD=10
    step(0, 0, 2'b00, 0, 4'd0,  4'd0, 0, 0, 0);
    step(0, 1, 2'b11, 0, 4'd7,  4'd7, 0, 0, 0);
    step(0, 1, 2'b01, 1, 4'd0,  4'd0, 0, 0, 0, 1'b1);
    for (int i = 1; i <= 12; i++)
      step(0, 1, 2'b01, 1, 4'd0, 4'(i % 10), (i % 10) == 9, (i % 10) == 0, 0);
    step(0, 1, 2'b01, 0, 4'd0,  4'd1, 0, 0, 0);
    step(0, 1, 2'b01, 0, 4'd0,  4'd0, 1, 0, 0);
    step(0, 1, 2'b01, 0, 4'd0,  4'd9, 0, 1, 0);
    step(0, 1, 2'b01, 0, 4'd0,  4'd8, 0, 0, 0);
    step(0, 1, 2'b01, 1, 4'd0,  4'd9, 1, 0, 0);
    step(0, 1, 2'b01, 1, 4'd0,  4'd0, 0, 1, 0);
    step(0, 1, 2'b00, 0, 4'd0,  4'd0, 0, 0, 0);
    step(0, 1, 2'b11, 0, 4'd5,  4'd5, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 1, 2'b00, 1, 4'd0, 4'd5, 0, 0, 0);
    step(0, 1, 2'b11, 0, 4'd9,  4'd9, 0, 0, 0);
    step(0, 1, 2'b01, 1, 4'd0,  4'd0, 0, 1, 0);
    step(0, 1, 2'b01, 1, 4'd0,  4'd1, 0, 0, 0);
    step(0, 1, 2'b11, 0, 4'd9,  4'd9, 0, 0, 0);
    step(0, 0, 2'b01, 1, 4'd0,  4'd0, 0, 0, 0);
    step(0, 1, 2'b11, 0, 4'd12, 4'd0, 0, 0, 1);
    step(0, 1, 2'b11, 0, 4'd9,  4'd9, 0, 0, 0);
    step(0, 1, 2'b11, 0, 4'd8,  4'd8, 0, 0, 0);
    step(0, 1, 2'b10, 0, 4'd3,  4'd0, 0, 0, 1);
    step(0, 1, 2'b10, 0, 4'd5,  4'd5, 0, 0, 0);
    step(0, 1, 2'b00, 0, 4'd0,  4'd5, 0, 0, 0);

    // DUT B: WIDTH=4, MOD=16
    step(1, 1, 2'b11, 0, 4'd5,  4'd5,  0, 0, 0);
    step(1, 1, 2'b10, 0, 4'd3,  4'd6,  0, 0, 0);
    step(1, 1, 2'b10, 0, 4'd0,  4'd6,  0, 0, 0);
    step(1, 1, 2'b11, 0, 4'd15, 4'd15, 0, 0, 0);
    step(1, 1, 2'b01, 1, 4'd0,  4'd0,  0, 1, 0);
    step(1, 1, 2'b01, 0, 4'd0,  4'd15, 0, 1, 0);
    step(1, 1, 2'b01, 0, 4'd0,  4'd14, 0, 0, 0);
    step(1, 1, 2'b01, 1, 4'd0,  4'd15, 1, 0, 0);

    // DUT C: WIDTH=1, MOD=2 (plain T flip-flop)
    step(2, 0, 2'b00, 0, 4'd0,  4'd0, 0, 0, 0);
    step(2, 1, 2'b10, 0, 4'd1,  4'd1, 0, 0, 0);
    step(2, 1, 2'b10, 0, 4'd1,  4'd0, 0, 0, 0);
    step(2, 1, 2'b10, 0, 4'd1,  4'd1, 0, 0, 0);
    step(2, 1, 2'b10, 0, 4'd0,  4'd1, 0, 0, 0);
    step(2, 1, 2'b01, 1, 4'd0,  4'd0, 0, 1, 0);
    step(2, 1, 2'b01, 1, 4'd0,  4'd1, 1, 0, 0);

    mode = 2'b00;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge ck);
    #3;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
